// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the arbitrated ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic ops, modulo add/sub with carry/borrow, zero-fill shifts.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] Z,
  output logic             C
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign shamt = B[SHW-1:0];
  assign sum   = {1'b0, A} + {1'b0, B};
  // The extra top bit of the difference is set exactly when A < B.
  assign diff  = {1'b0, A} - {1'b0, B};

  always_comb begin
    Z = '0;
    C = 1'b0;
    case (op)
      OP_AND: Z = A & B;
      OP_OR:  Z = A | B;
      OP_XOR: Z = A ^ B;
      OP_ADD: begin
        Z = sum[WIDTH-1:0];
        C = sum[WIDTH];
      end
      OP_SUB: begin
        Z = diff[WIDTH-1:0];
        C = diff[WIDTH];
      end
      OP_NOR: Z = ~(A | B);
      OP_SRL: Z = A >> shamt;
      OP_SLL: Z = A << shamt;
      default: begin
        Z = '0;
        C = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU; one operation in flight,
// IDLE -> EXEC -> RESP sequencing with a held response until rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_A,
  input  logic [2*WIDTH-1:0] req_B,
  input  logic [5:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_Z,
  output logic               rsp_C,
  output logic               rsp_zero
);

  state_t state, state_nxt;
  logic       last_grant;
  logic [1:0] grant;
  logic       accept;
  logic       sel;

  logic [WIDTH-1:0] a_p0, b_p0;
  logic [2:0]       op_p0;
  logic             id_p0;

  logic [WIDTH-1:0] alu_z;
  logic             alu_c;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state == ST_IDLE && rst_n) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel       = req_ready[1];
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_EXEC;
      ST_EXEC:                state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= sel;
    end
  end

  // Stage p0: capture the granted requester's operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= sel ? req_A[2*WIDTH-1:WIDTH] : req_A[WIDTH-1:0];
      b_p0  <= sel ? req_B[2*WIDTH-1:WIDTH] : req_B[WIDTH-1:0];
      op_p0 <= sel ? req_op[5:3] : req_op[2:0];
      id_p0 <= sel;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .A  (a_p0),
    .B  (b_p0),
    .op (op_p0),
    .Z  (alu_z),
    .C  (alu_c)
  );

  // Stage p1: register the ALU result; held through RESP until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_Z    <= '0;
      rsp_C    <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_Z    <= alu_z;
      rsp_C    <= alu_c;
      rsp_zero <= (alu_z == '0);
      rsp_id   <= id_p0;
    end
  end

endmodule
